dt_peak_scan: RTL and testbench

Post-processing stage downstream of the distance-transform engine. Once the transform finishes, the block sweeps the 128×128 result memory in raster order. It reports the largest distance, where that distance first occurs, and how many object pixels the image holds. It shares the result-memory read port with the transform engine; the top level grants it access only after the engine's `done` is asserted.

---
 rtl/dt_pkg.sv | 27 ++
 rtl/dt_hist_bank.sv | 64 ++++++
 rtl/dt_peak_scan.sv | 180 ++++++++++++++++++
 tb/tb_dt_peak_scan.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// -----------------------------------------------------------------------------
// dt_pkg
// Shared constants and types for the distance-transform post-processing
// blocks.
//   DT_ADDR_W     : result-memory address width (image holds 2^DT_ADDR_W px)
//   DT_DATA_W     : distance value width
//   DT_IMG_N      : pixel count of the 128x128 image
//   DT_HIST_BINS  : number of histogram bins (optional histogram)
//   DT_HIST_SEL_W : width of the histogram bin select
//   dt_scan_state_t : peak-scan controller states
// -----------------------------------------------------------------------------
package dt_pkg;

   localparam int DT_ADDR_W     = 14;
   localparam int DT_DATA_W     = 8;
   localparam int DT_IMG_N      = 16384;
   localparam int DT_HIST_BINS  = 16;
   localparam int DT_HIST_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dt_scan_state_t;

endpackage : dt_pkg

// File: rtl/dt_hist_bank.sv
// -----------------------------------------------------------------------------
// dt_hist_bank
// 16-bin histogram of distance samples. Values 0..14 land in their own bin,
// everything >= 15 saturates into bin 15. The selected bin is read
// combinationally.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears all bins
//   clr_i  : synchronous clear of all bins (new scan starting)
//   inc_i  : d_i is a valid sample this cycle
//   d_i    : distance sample
//   sel_i  : bin select for cnt_o
//   cnt_o  : count held in bin sel_i
// -----------------------------------------------------------------------------
module dt_hist_bank
   import dt_pkg::*;
#(
   parameter int DATA_W = DT_DATA_W,
   parameter int CNT_W  = DT_ADDR_W + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     inc_i,
   input  logic [DATA_W-1:0]        d_i,
   input  logic [DT_HIST_SEL_W-1:0] sel_i,
   output logic [CNT_W-1:0]         cnt_o
);

   localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
   localparam logic [DATA_W-1:0]        SAT_VAL  = DATA_W'(DT_HIST_BINS - 1);
   localparam logic [DT_HIST_SEL_W-1:0] SAT_BIN  = DT_HIST_SEL_W'(DT_HIST_BINS - 1);

   logic [DT_HIST_SEL_W-1:0] bin_idx;
   logic [DT_HIST_BINS-1:0]  hit;
   logic [CNT_W-1:0]         bin_q [DT_HIST_BINS];

   // Saturating bin index: large distances all collapse into the top bin.
   assign bin_idx = (d_i < SAT_VAL) ? d_i[DT_HIST_SEL_W-1:0] : SAT_BIN;

   // One-hot increment strobe per bin.
   generate
      for (genvar gi = 0; gi < DT_HIST_BINS; gi++) begin : g_hit
         assign hit[gi] = inc_i && (bin_idx == DT_HIST_SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         for (int i = 0; i < DT_HIST_BINS; i++) begin
            bin_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DT_HIST_BINS; i++) begin
            if (hit[i]) begin
               bin_q[i] <= bin_q[i] + CNT_ONE;
            end
         end
      end
   end

   assign cnt_o = bin_q[sel_i];

endmodule : dt_hist_bank

// File: rtl/dt_peak_scan.sv
// -----------------------------------------------------------------------------
// dt_peak_scan
// Raster sweep of the distance-transform result memory after the transform
// completes. Reports the largest distance, the address of its first
// occurrence and the number of nonzero (object) pixels.
//
// Optional feature: define DT_PEAK_HIST_EN to build a 16-bin histogram and
// expose the hist_sel / hist_cnt ports. Without it those ports are absent.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   start    : one-cycle pulse, begins a scan from IDLE or DONE
//   res_rd   : result-memory read enable
//   res_addr : result-memory read address
//   res_di   : read data, returned one cycle after res_addr/res_rd
//   busy     : scan in progress
//   valid    : results final (level, held until next start or reset)
//   max_dist : largest distance read
//   max_addr : raster address of the first occurrence of max_dist
//   obj_cnt  : number of nonzero pixels
//   hist_sel : histogram bin select            (DT_PEAK_HIST_EN only)
//   hist_cnt : count in selected bin           (DT_PEAK_HIST_EN only)
// -----------------------------------------------------------------------------
module dt_peak_scan
   import dt_pkg::*;
#(
   parameter int ADDR_W = DT_ADDR_W,
   parameter int DATA_W = DT_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     res_rd,
   output logic [ADDR_W-1:0]        res_addr,
   input  logic [DATA_W-1:0]        res_di,
   output logic                     busy,
   output logic                     valid,
   output logic [DATA_W-1:0]        max_dist,
   output logic [ADDR_W-1:0]        max_addr,
   output logic [ADDR_W:0]          obj_cnt
`ifdef DT_PEAK_HIST_EN
   ,
   input  logic [DT_HIST_SEL_W-1:0] hist_sel,
   output logic [ADDR_W:0]          hist_cnt
`endif
);

   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   dt_scan_state_t    state_q, state_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   // pend_q marks that res_di carries the sample for addr_dly_q this cycle.
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] addr_dly_q, addr_dly_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] max_dist_q, max_dist_d;
   logic [ADDR_W-1:0] max_addr_q, max_addr_d;
   logic [CNT_W-1:0]  obj_cnt_q, obj_cnt_d;
   logic              scan_clr;

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      busy_d     = busy_q;
      valid_d    = valid_q;
      max_dist_d = max_dist_q;
      max_addr_d = max_addr_q;
      obj_cnt_d  = obj_cnt_q;
      // The read issued this cycle returns data next cycle.
      pend_d     = rd_q;
      addr_dly_d = addr_q;
      scan_clr   = 1'b0;

      // Sample processing. Strict compare keeps the earliest address on ties.
      if (pend_q) begin
         if (res_di > max_dist_q) begin
            max_dist_d = res_di;
            max_addr_d = addr_dly_q;
         end
         if (res_di != '0) begin
            obj_cnt_d = obj_cnt_q + CNT_ONE;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = SCAN;
               scan_clr   = 1'b1;
               rd_d       = 1'b1;
               addr_d     = '0;
               busy_d     = 1'b1;
               valid_d    = 1'b0;
               max_dist_d = '0;
               max_addr_d = '0;
               obj_cnt_d  = '0;
            end
         end
         SCAN: begin
            // Last address is on the port now; stop reading after this cycle.
            if (addr_q == ADDR_LAST) begin
               state_d = DRAIN;
               rd_d    = 1'b0;
            end else begin
               addr_d = addr_q + ADDR_ONE;
            end
         end
         DRAIN: begin
            // The final sample is folded in on this edge.
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         pend_q     <= 1'b0;
         addr_dly_q <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         max_dist_q <= '0;
         max_addr_q <= '0;
         obj_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         pend_q     <= pend_d;
         addr_dly_q <= addr_dly_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         max_dist_q <= max_dist_d;
         max_addr_q <= max_addr_d;
         obj_cnt_q  <= obj_cnt_d;
      end
   end

   assign res_rd   = rd_q;
   assign res_addr = addr_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign max_dist = max_dist_q;
   assign max_addr = max_addr_q;
   assign obj_cnt  = obj_cnt_q;

`ifdef DT_PEAK_HIST_EN
   dt_hist_bank #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_hist (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (scan_clr),
      .inc_i  (pend_q),
      .d_i    (res_di),
      .sel_i  (hist_sel),
      .cnt_o  (hist_cnt)
   );
`else
   // No histogram in this build; scan_clr only feeds the histogram.
   logic unused_scan_clr;
   assign unused_scan_clr = scan_clr;
`endif

endmodule : dt_peak_scan

// File: tb/tb_dt_peak_scan.sv
// -----------------------------------------------------------------------------
// tb_dt_peak_scan
// Scoreboarded bench: the stimulus process computes expected results from the
// image contents and queues them when it issues an accepted start; a monitor
// on the falling edge pops and compares when valid rises, and also checks the
// read-port timing of every scan.
// -----------------------------------------------------------------------------
module tb_dt_peak_scan;

   localparam int N = 16384;

   typedef struct {
      int md;
      int ma;
      int oc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di = 8'd0;
   logic        busy;
   logic        valid;
   logic [7:0]  max_dist;
   logic [13:0] max_addr;
   logic [14:0] obj_cnt;
`ifdef DT_PEAK_HIST_EN
   logic [3:0]  hist_sel;
   logic [14:0] hist_cnt;
`endif

   logic [7:0]  mem [N];
   exp_t        sb_q [$];
   int          exp_hist [16];

   int vectors  = 0;
   int miscmp   = 0;
   int done_cnt = 0;

   dt_peak_scan dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .res_rd   (res_rd),
      .res_addr (res_addr),
      .res_di   (res_di),
      .busy     (busy),
      .valid    (valid),
      .max_dist (max_dist),
      .max_addr (max_addr),
`ifdef DT_PEAK_HIST_EN
      .hist_sel (hist_sel),
      .hist_cnt (hist_cnt),
`endif
      .obj_cnt  (obj_cnt)
   );

   always #5 clk = ~clk;

   // Result memory with a registered one-cycle read.
   always @(posedge clk) begin
      if (res_rd) res_di <= mem[res_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: straight from the rules -- largest value, first address at
   // which it appears, number of nonzero pixels, saturating histogram.
   task automatic model(output exp_t e);
      e.md = 0; e.ma = 0; e.oc = 0;
      for (int b = 0; b < 16; b++) exp_hist[b] = 0;
      for (int i = 0; i < N; i++) begin
         int v;
         v = int'(mem[i]);
         if (v > e.md) begin
            e.md = v;
            e.ma = i;
         end
         if (v != 0) e.oc++;
         exp_hist[(v < 15) ? v : 15]++;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int edge_n     = 0;
   bit active     = 1'b0;
   bit prev_valid = 1'b0;
   int e0, rd_cnt, exp_addr, addr_err;

   always @(negedge clk) begin
      exp_t e;
      edge_n++;
      if (reset) begin
         active = 1'b0;
      end else begin
         if (active) begin
            if (edge_n == e0) begin
               chk("start_busy", busy, 1);
               chk("start_valid_drop", valid, 0);
            end
            if (res_rd) begin
               if (res_addr != exp_addr[13:0]) addr_err++;
               exp_addr++;
               rd_cnt++;
            end
            if (valid && !prev_valid) begin
               if (sb_q.size() == 0) begin
                  chk("sb_entry_present", 0, 1);
               end else begin
                  e = sb_q.pop_front();
                  chk("max_dist", max_dist, e.md);
                  chk("max_addr", max_addr, e.ma);
                  chk("obj_cnt", obj_cnt, e.oc);
                  chk("valid_latency", edge_n - e0, 16385);
                  chk("rd_cycles", rd_cnt, N);
                  chk("addr_seq_errors", addr_err, 0);
                  chk("busy_at_done", busy, 0);
               end
               active = 1'b0;
               done_cnt++;
            end
         end else if (valid && !prev_valid) begin
            chk("unexpected_valid", 1, 0);
         end
         if (start && !active) begin
            active   = 1'b1;
            e0       = edge_n + 1;
            rd_cnt   = 0;
            exp_addr = 0;
            addr_err = 0;
         end
      end
      prev_valid = valid;
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic issue_scan();
      exp_t e;
      model(e);
      sb_q.push_back(e);
      pulse_start();
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt < target) begin
         vectors++;
         miscmp++;
         $display("FAIL wait_valid: timed out after %0d cycles, expected valid", n);
      end
      #2;
   endtask

   task automatic check_hist();
`ifdef DT_PEAK_HIST_EN
      for (int b = 0; b < 16; b++) begin
         hist_sel = b[3:0];
         #1;
         chk($sformatf("hist_bin%0d", b), hist_cnt, exp_hist[b]);
      end
`endif
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_res_rd"}, res_rd, 0);
      chk({tag, "_res_addr"}, res_addr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_max_dist"}, max_dist, 0);
      chk({tag, "_max_addr"}, max_addr, 0);
      chk({tag, "_obj_cnt"}, obj_cnt, 0);
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N; i++) mem[i] = v[7:0];
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
   endtask

   initial begin
      exp_t dummy;
      reset = 1'b1;
      start = 1'b0;
`ifdef DT_PEAK_HIST_EN
      hist_sel = 4'd0;
`endif
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b0;

      // 1: all-zero image
      issue_scan();
      wait_done(1);
      check_hist();

      // 2: restart from DONE with a changed image (tie case)
      fill(0);
      mem[200] = 8'd9; mem[300] = 8'd9; mem[50] = 8'd3;
      issue_scan();
      wait_done(2);
      check_hist();

      // 3: all 0xFF, extra start mid-scan is ignored
      fill(255);
      issue_scan();
      repeat (5000) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(3);
      check_hist();

      // 4: reset mid-scan on a random image
      fill_random();
      issue_scan();
      repeat (8000) @(posedge clk);
      #1 reset = 1'b1;
      sb_q.delete();
      @(posedge clk); #1;
      check_zero_outputs("midreset");
      model(dummy);
      for (int b = 0; b < 16; b++) exp_hist[b] = 0;
      check_hist();
      reset = 1'b0;

      // 5: fresh start, single object pixel
      fill(0);
      mem[1000] = 8'd5;
      issue_scan();
      wait_done(4);
      check_hist();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_dt_peak_scan
